// File: rtl/memory_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter_if
// Bundles the two requester handshakes (instruction fetch, data stage), the
// single-port memory strobe/data, and the pipeline stall outputs.
//
//   slave  : the arbiter side (consumes requests, drives memory and stalls)
//   master : the environment side (pipeline requesters plus the memory,
//            which returns mem_rdata)
//
// Signals
//   if_req/if_addr            fetch request, held until if_valid
//   if_valid/if_rdata         fetch completion pulse and fetched word
//   dm_req/dm_we/dm_addr/
//   dm_wdata                  data-stage request, held until dm_done
//   dm_done/dm_rdata          data completion pulse and read data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata       single-port memory access
//   stall_if/stall_dm         stall indications to pipeline control
// ---------------------------------------------------------------------------
interface memory_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 19
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_dm;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_valid, if_rdata, dm_done, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_valid, if_rdata, dm_done, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter
// Shares one single-port memory between the instruction fetch stage and the
// data-memory stage. One access is in flight at a time; each access strobes
// the memory for one cycle, waits MEM_LAT cycles for read data, then signals
// completion to its requester and returns to IDLE (period MEM_LAT+2 cycles).
// Simultaneous requests are resolved round-robin on the last grant.
//
// Ports
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    memory_port_arbiter_if.slave (requesters, memory, stalls)
//
// Parameters
//   ADDR_W   memory word address width
//   DATA_W   memory word width (instruction width)
//   MEM_LAT  cycles from the mem_en cycle to valid mem_rdata, 1..3
// ---------------------------------------------------------------------------
module memory_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 19,
  parameter int MEM_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  memory_port_arbiter_if.slave   bus
);

  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              last_dm;
  logic              grant;
  logic              grant_dm;
  logic              done_cyc;

  logic              mem_en_p1;
  logic              mem_we_p1;
  logic [ADDR_W-1:0] mem_addr_p1;
  logic [DATA_W-1:0] mem_wdata_p1;

  logic              if_valid_c;
  logic              dm_done_c;

  // Next-state: arbitrate only from IDLE, so the completion cycle never grants.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    grant_dm  = 1'b0;
    done_cyc  = (cnt == CNT_DONE);
    case (state)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          grant = 1'b1;
          // DM wins alone, or on a tie when IF was granted last.
          grant_dm  = bus.dm_req && (!bus.if_req || !last_dm);
          state_nxt = grant_dm ? BUSY_DM : BUSY_IF;
          cnt_nxt   = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (done_cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register and p1 memory strobe stage: the granted requester's
  // inputs are captured at the grant edge, so later changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_dm      <= 1'b0;
      mem_en_p1    <= 1'b0;
      mem_we_p1    <= 1'b0;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_en_p1 <= grant;
      mem_we_p1 <= grant && grant_dm && bus.dm_we;
      if (grant) begin
        last_dm <= grant_dm;
      end
      if (!grant) begin
        mem_addr_p1 <= '0;
      end else if (grant_dm) begin
        mem_addr_p1 <= bus.dm_addr;
      end else begin
        mem_addr_p1 <= bus.if_addr;
      end
      mem_wdata_p1 <= (grant && grant_dm) ? bus.dm_wdata : '0;
    end
  end

  // Outputs: completion is suppressed if the requester withdrew its request.
  always_comb begin
    if_valid_c    = (state == BUSY_IF) && done_cyc && bus.if_req;
    dm_done_c     = (state == BUSY_DM) && done_cyc && bus.dm_req;
    bus.if_valid  = if_valid_c;
    bus.dm_done   = dm_done_c;
    bus.if_rdata  = bus.mem_rdata;
    bus.dm_rdata  = bus.mem_rdata;
    bus.stall_if  = bus.if_req && !if_valid_c;
    bus.stall_dm  = bus.dm_req && !dm_done_c;
    bus.mem_en    = mem_en_p1;
    bus.mem_we    = mem_we_p1;
    bus.mem_addr  = mem_addr_p1;
    bus.mem_wdata = mem_wdata_p1;
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_port_arbiter
// Directed scenarios against a behavioural single-port memory with MEM_LAT
// read latency. Expected completions are queued per requester when a request
// is issued and popped when if_valid / dm_done appears.
// ---------------------------------------------------------------------------
module tb_memory_port_arbiter;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 19;
  localparam int MEM_LAT  = 2;
  localparam int WAIT_MAX = 2 * (MEM_LAT + 2) + 1;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;

  always #5 clk = ~clk;

  memory_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory model: unwritten words read a fixed address-derived pattern.
  logic [DATA_W-1:0] mem     [2**ADDR_W];
  logic              written [2**ADDR_W];
  logic [DATA_W-1:0] rd_pipe [MEM_LAT];

  function automatic logic [DATA_W-1:0] init_word(logic [ADDR_W-1:0] a);
    if (a == 12'h010) return 19'h1ABCD;
    return DATA_W'({a, 7'h2A});
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2**ADDR_W; i++) written[i] <= 1'b0;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= !bus.mem_en ? '0 :
                  (written[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr));
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  // Scoreboard and checking
  exp_t if_q[$];
  exp_t dm_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(logic we, logic [DATA_W-1:0] d);
    exp_t e;
    e.we   = we;
    e.data = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.if_valid) begin
      if (if_q.size() == 0) begin
        chk("if_valid_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = if_q.pop_front();
        chk("if_rdata", 32'(bus.if_rdata), 32'(mon_e.data));
      end
    end
    if (bus.dm_done) begin
      if (dm_q.size() == 0) begin
        chk("dm_done_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = dm_q.pop_front();
        if (!mon_e.we) chk("dm_rdata", 32'(bus.dm_rdata), 32'(mon_e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Both wait tasks start and end at a falling edge.
  task automatic wait_dm(int bound);
    int k = 0;
    while (!bus.dm_done && k < bound) begin
      step();
      neg();
      k++;
    end
    chk("dm_done_within_bound", 32'(bus.dm_done), 32'd1);
  endtask

  task automatic wait_if(int bound);
    int k = 0;
    while (!bus.if_valid && k < bound) begin
      step();
      neg();
      k++;
    end
    chk("if_valid_within_bound", 32'(bus.if_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_dm;
    logic is_dm;
    logic own_if;
    logic own_dm;
    int   w_if;
    int   w_dm;
    int   grants;

    reset        = 1'b1;
    mem_clr      = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;

    // Reset state
    step();
    step();
    neg();
    chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_if_valid",  32'(bus.if_valid),  32'd0);
    chk("rst_dm_done",   32'(bus.dm_done),   32'd0);
    mem_clr = 1'b0;
    step();
    reset = 1'b0;
    neg();

    // IF-only read of 0x010
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h010;
    if_q.push_back(mk(1'b0, 19'h1ABCD));
    neg();
    chk("s1_stall_if_c0", 32'(bus.stall_if), 32'd1);
    chk("s1_mem_en_c0",   32'(bus.mem_en),   32'd0);
    step(); neg();
    chk("s1_mem_en_c1",   32'(bus.mem_en),   32'd1);
    chk("s1_mem_addr_c1", 32'(bus.mem_addr), 32'h010);
    chk("s1_mem_we_c1",   32'(bus.mem_we),   32'd0);
    chk("s1_stall_if_c1", 32'(bus.stall_if), 32'd1);
    step(); neg();
    chk("s1_mem_en_c2",   32'(bus.mem_en),   32'd0);
    chk("s1_stall_if_c2", 32'(bus.stall_if), 32'd1);
    chk("s1_if_valid_c2", 32'(bus.if_valid), 32'd0);
    step(); neg();
    chk("s1_if_valid_c3", 32'(bus.if_valid), 32'd1);
    chk("s1_stall_if_c3", 32'(bus.stall_if), 32'd0);
    step();
    bus.if_req = 1'b0;
    neg();
    chk("s1_if_valid_c4", 32'(bus.if_valid), 32'd0);

    // DM write 0x00055 to 0x020; inputs change after the grant edge
    step();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 12'h020;
    bus.dm_wdata = 19'h00055;
    dm_q.push_back(mk(1'b1, '0));
    neg();
    chk("s2_stall_dm_c0", 32'(bus.stall_dm), 32'd1);
    step();
    bus.dm_addr  = 12'h7FF;
    bus.dm_wdata = 19'h3FFFF;
    neg();
    chk("s2_mem_en_c1",    32'(bus.mem_en),    32'd1);
    chk("s2_mem_we_c1",    32'(bus.mem_we),    32'd1);
    chk("s2_mem_addr_c1",  32'(bus.mem_addr),  32'h020);
    chk("s2_mem_wdata_c1", 32'(bus.mem_wdata), 32'h00055);
    step(); neg();
    chk("s2_mem_en_c2",    32'(bus.mem_en),    32'd0);
    chk("s2_mem_we_c2",    32'(bus.mem_we),    32'd0);
    chk("s2_mem_wdata_c2", 32'(bus.mem_wdata), 32'd0);
    step(); neg();
    chk("s2_dm_done_c3",   32'(bus.dm_done),   32'd1);
    chk("s2_stall_dm_c3",  32'(bus.stall_dm),  32'd0);
    step();
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    neg();
    // Readback of the written word and of the address changed after grant
    step();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 12'h020;
    dm_q.push_back(mk(1'b0, 19'h00055));
    neg();
    wait_dm(6);
    step();
    bus.dm_req = 1'b0;
    neg();
    step();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 12'h7FF;
    dm_q.push_back(mk(1'b0, init_word(12'h7FF)));
    neg();
    wait_dm(6);
    step();
    bus.dm_req = 1'b0;
    neg();

    // Both requests rise together right after reset: DM first
    step();
    reset = 1'b1;
    step();
    reset       = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h010;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 12'h020;
    if_q.push_back(mk(1'b0, 19'h1ABCD));
    dm_q.push_back(mk(1'b0, 19'h00055));
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        step();
        if (c == 4) bus.dm_req = 1'b0;
      end
      neg();
      chk($sformatf("s3_stall_if_c%0d", c), 32'(bus.stall_if), 32'(c <= 6));
      chk($sformatf("s3_mem_en_c%0d", c),   32'(bus.mem_en),   32'(c == 1 || c == 5));
      chk($sformatf("s3_dm_done_c%0d", c),  32'(bus.dm_done),  32'(c == 3));
      chk($sformatf("s3_if_valid_c%0d", c), 32'(bus.if_valid), 32'(c == 7));
      if (c == 1) chk("s3_mem_addr_c1", 32'(bus.mem_addr), 32'h020);
      if (c == 5) chk("s3_mem_addr_c5", 32'(bus.mem_addr), 32'h010);
    end
    step();
    bus.if_req = 1'b0;
    neg();

    // Fetch withdrawn in cycle 2 while a DM request waits
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h010;
    neg();
    step();
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 12'h020;
    dm_q.push_back(mk(1'b0, 19'h00055));
    neg();
    chk("s4_mem_en_c1",   32'(bus.mem_en),   32'd1);
    chk("s4_mem_addr_c1", 32'(bus.mem_addr), 32'h010);
    chk("s4_stall_dm_c1", 32'(bus.stall_dm), 32'd1);
    step();
    bus.if_req = 1'b0;
    neg();
    chk("s4_stall_if_c2", 32'(bus.stall_if), 32'd0);
    step(); neg();
    chk("s4_if_valid_c3", 32'(bus.if_valid), 32'd0);
    chk("s4_stall_dm_c3", 32'(bus.stall_dm), 32'd1);
    step(); neg();
    chk("s4_idle_c4",     32'(dut.state),    32'd0);
    chk("s4_mem_en_c4",   32'(bus.mem_en),   32'd0);
    chk("s4_stall_dm_c4", 32'(bus.stall_dm), 32'd1);
    step(); neg();
    chk("s4_mem_en_c5",   32'(bus.mem_en),   32'd1);
    chk("s4_mem_addr_c5", 32'(bus.mem_addr), 32'h020);
    wait_dm(4);
    step();
    bus.dm_req = 1'b0;
    neg();

    // Reset in cycle 2 of a DM read, request held across reset
    step();
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 12'h010;
    dm_q.push_back(mk(1'b0, 19'h1ABCD));
    neg();
    step(); neg();
    chk("s5_mem_en_c1", 32'(bus.mem_en), 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("s5_rst_mem_en",    32'(bus.mem_en),   32'd0);
    chk("s5_rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    chk("s5_rst_dm_done",   32'(bus.dm_done),  32'd0);
    chk("s5_rst_stall_dm",  32'(bus.stall_dm), 32'd1);
    neg();
    chk("s5_rst_dm_done_n", 32'(bus.dm_done),  32'd0);
    step();
    reset = 1'b0;
    neg();
    chk("s5_rel_mem_en",    32'(bus.mem_en),   32'd0);
    step(); neg();
    chk("s5_regrant_en",    32'(bus.mem_en),   32'd1);
    chk("s5_regrant_addr",  32'(bus.mem_addr), 32'h010);
    wait_dm(4);
    step();
    bus.dm_req = 1'b0;
    neg();
    chk("q_if_empty", 32'(if_q.size()), 32'd0);
    chk("q_dm_empty", 32'(dm_q.size()), 32'd0);

    // Both held high for 20 cycles: alternating grants, bounded waits
    step();
    reset = 1'b1;
    step();
    reset       = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h100;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 12'h200;
    if_q.push_back(mk(1'b0, init_word(12'h100)));
    dm_q.push_back(mk(1'b0, init_word(12'h200)));
    exp_dm = 1'b1;
    own_if = 1'b0;
    own_dm = 1'b0;
    w_if   = 0;
    w_dm   = 0;
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      neg();
      if (bus.mem_en) begin
        is_dm = (bus.mem_addr == 12'h200);
        chk($sformatf("s6_alt_g%0d", grants), 32'(is_dm), 32'(exp_dm));
        exp_dm = !exp_dm;
        grants++;
        if (is_dm) begin
          chk("s6_wait_dm", 32'(w_dm <= WAIT_MAX), 32'd1);
          own_dm = 1'b1;
          w_dm   = 0;
        end else begin
          chk("s6_wait_if", 32'(w_if <= WAIT_MAX), 32'd1);
          own_if = 1'b1;
          w_if   = 0;
        end
      end
      // Requests stay high, so each completion re-issues the same access.
      if (bus.if_valid) begin
        own_if = 1'b0;
        if_q.push_back(mk(1'b0, init_word(12'h100)));
      end else if (!own_if) begin
        w_if++;
      end
      if (bus.dm_done) begin
        own_dm = 1'b0;
        dm_q.push_back(mk(1'b0, init_word(12'h200)));
      end else if (!own_dm) begin
        w_dm++;
      end
    end
    chk("s6_grant_count", 32'(grants), 32'd5);
    step();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    neg();
    step(); neg();
    chk("s6_quiet_mem_en", 32'(bus.mem_en), 32'd0);
    if_q.delete();
    dm_q.delete();

    // Final IF read after the stress run
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h010;
    if_q.push_back(mk(1'b0, 19'h1ABCD));
    neg();
    wait_if(6);
    step();
    bus.if_req = 1'b0;
    neg();
    chk("final_q_if_empty", 32'(if_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
